pix_v1_hit_readout: RTL and testbench
=====================================

# pix_v1_hit_readout

Acquisition block paired with the PIX_V1_SW_28_10_19 sequencer. The sequencer drives the test structure and raises `measure_flag` for the measurement window. This block observes the structure's discriminated `HIT` output during that window and time-stamps the first rising edge and the last falling edge relative to window start. It also counts leading edges. One result word per window is queued into a small FIFO that the host drains with a valid/ready handshake.

## Interface
- `TIME_WIDTH`, 10, width of window counter and time stamps (matches sequencer time inputs)
- `FIFO_DEPTH`, 4, result FIFO entries, power of two, ≥2
- `clk`  in  1  system clock, all logic on rising edge
- `_reset`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- `measure_flag`  in  1  sequencer measurement window, synchronous to `clk`
- `HIT`  in  1  test-structure discriminator output, asynchronous
- `data_out`  out  2*TIME_WIDTH+5  head of FIFO: {hit_count[3:0], no_hit, leading_time, trailing_time}
- `data_valid`  out  1  FIFO not empty
- `data_ready`  in  1  host accepts `data_out` this cycle
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries held
- `busy`  out  1  state ≠ IDLE
- `dropped_count`  out  8  results discarded on full FIFO (only with `HIT_READOUT_DROP_COUNT_EN`)

## Operation
- `HIT` passes through a 2-FF synchronizer (`hit_s`), then a delay register (`hit_d`). Rise: `hit_s & ~hit_d`; fall: `~hit_s & hit_d`. `hit_d` updates every cycle in every state, so a level already high at window start is not an edge.
- States:
  - IDLE: window counter, stamps and hit count cleared. Go to ARMED when `measure_flag`=1.
  - ARMED: counter increments each cycle and saturates at all-ones.
    - First rise: `leading_time` := counter value in that cycle.
    - Every rise: `hit_count` += 1, saturating at 15.
    - Every fall after a recorded rise: `trailing_time` := counter value.
    - `measure_flag`=0 → STORE.
  - STORE: one cycle; build the word and push it, then go to IDLE.
- Word fields:
  - `no_hit`=1 iff no rise was seen; leading/trailing are then 0.
  - `trailing_time` = all-ones if `hit_s` is still high when ARMED exits.
  - A fall with no prior rise is ignored.
- Time stamps include the 2-cycle synchronizer latency; they are not compensated.
- FIFO:
  - Push in STORE if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the word is dropped.
  - Pop when `data_valid & data_ready`.
  - `data_out` shows the head entry and is stable while `data_valid` is high and no pop occurs.

## Timing
- Reset values, all outputs 0:
  - `data_valid`=0, `data_out`=0, `fifo_count`=0, `busy`=0, `dropped_count`=0.
  - State IDLE, synchronizer flops 0.
- First ARMED cycle has counter = 0. `measure_flag` high for N cycles gives counter values 0..N-1, then STORE on the cycle after the flag drops.
- `HIT` rising at cycle t (before the clk edge) produces a rise detection 2 cycles later.
- Result push latency: `data_valid` rises 1 cycle after STORE, i.e. 2 cycles after `measure_flag` falls.
- Simultaneous push and pop when empty: `data_valid` stays 0 → push is visible next cycle; pop is ignored since nothing is valid.
- If `measure_flag` is high during STORE, ARMED re-enters one cycle later; that window's counter starts late by one cycle.
- `_reset` asserted mid-window discards the in-progress measurement and FIFO contents immediately.

## Configuration
- `HIT_READOUT_DROP_COUNT_EN` defined:
  - `dropped_count` port exists.
  - It increments by 1 on each dropped word and saturates at 255.
  - Cleared only by reset.
- Not defined: the port and the counter are absent; drops are silent.

## Test plan
- Window of 50 cycles, `HIT` pulses high over cycles 10–19 of window → word hit_count=1, no_hit=0, leading=12, trailing=22.
- Window 30, `HIT` held low → no_hit=1, hit_count=0, leading=0, trailing=0, `data_valid` rises 2 cycles after `measure_flag` falls.
- Window 100, 20 separate pulses → hit_count=15 (saturated), leading = first pulse stamp, trailing = last fall stamp.
- `TIME_WIDTH`=4, window 40, single rise at cycle 25 held high past end → leading=15, trailing=15.
- `data_ready`=0, 6 windows → `fifo_count`=4, two words dropped, `dropped_count`=2 (macro on). Then `data_ready`=1 pops the 4 words in order.
- Full FIFO with pop coinciding with STORE → no drop, `fifo_count` stays 4; `_reset` low mid-window → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/pix_v1_hit_readout.sv
// HIT time-stamping for one sequencer measurement window, with a small result FIFO.
// Define HIT_READOUT_DROP_COUNT_EN to add the saturating dropped_count output.
module pix_v1_hit_readout #(
    parameter int unsigned TIME_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          _reset,
    input  logic                          measure_flag,
    input  logic                          HIT,
    output logic [2*TIME_WIDTH+4:0]       data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
`ifdef HIT_READOUT_DROP_COUNT_EN
    ,
    output logic [7:0]                    dropped_count
`endif
);

    localparam int unsigned WordWidth = 2 * TIME_WIDTH + 5;
    localparam int unsigned PtrWidth  = $clog2(FIFO_DEPTH);
    localparam logic [PtrWidth:0] DepthCount = FIFO_DEPTH[PtrWidth:0];

    typedef enum logic [1:0] {StIdle, StArmed, StStore} state_e;

    state_e                state_q, state_d;
    logic                  hit_meta, hit_s, hit_d;
    logic                  rise, fall;
    logic [TIME_WIDTH-1:0] cnt_q, cnt_d, lead_q, lead_d, trail_q, trail_d;
    logic [3:0]            hits_q, hits_d;
    logic                  seen_q, seen_d;
    logic                  push_req, push, pop, full;
    logic [WordWidth-1:0]  word;
    logic [WordWidth-1:0]  mem [FIFO_DEPTH];
    logic [PtrWidth-1:0]   wr_ptr, rd_ptr;
    logic [PtrWidth:0]     count_q;

    assign rise = hit_s & ~hit_d;
    assign fall = ~hit_s & hit_d;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            hit_meta <= 1'b0;
            hit_s    <= 1'b0;
            hit_d    <= 1'b0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            lead_q   <= '0;
            trail_q  <= '0;
            hits_q   <= '0;
            seen_q   <= 1'b0;
        end else begin
            hit_meta <= HIT;
            hit_s    <= hit_meta;
            hit_d    <= hit_s;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lead_q   <= lead_d;
            trail_q  <= trail_d;
            hits_q   <= hits_d;
            seen_q   <= seen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lead_d   = lead_q;
        trail_d  = trail_q;
        hits_d   = hits_q;
        seen_d   = seen_q;
        push_req = 1'b0;
        word     = '0;
        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                lead_d  = '0;
                trail_d = '0;
                hits_d  = '0;
                seen_d  = 1'b0;
                if (measure_flag) state_d = StArmed;
            end
            StArmed: begin
                if (cnt_q != {TIME_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
                if (rise) begin
                    if (!seen_q) lead_d = cnt_q;
                    seen_d = 1'b1;
                    if (hits_q != 4'hf) hits_d = hits_q + 4'd1;
                end else if (fall && seen_q) begin
                    trail_d = cnt_q;
                end
                if (!measure_flag) state_d = StStore;
            end
            StStore: begin
                push_req = 1'b1;
                // hit_d here is hit_s from the last ARMED cycle
                if (seen_q) begin
                    word = {hits_q, 1'b0, lead_q, hit_d ? {TIME_WIDTH{1'b1}} : trail_q};
                end else begin
                    word = {4'd0, 1'b1, {(2 * TIME_WIDTH){1'b0}}};
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign data_valid = (count_q != '0);
    assign fifo_count = count_q;
    assign full       = (count_q == DepthCount);
    assign pop        = data_valid & data_ready;
    assign push       = push_req & (~full | pop);
    assign data_out   = data_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef HIT_READOUT_DROP_COUNT_EN
    logic drop;
    assign drop = push_req & full & ~pop;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            dropped_count <= '0;
        end else if (drop && (dropped_count != 8'hff)) begin
            dropped_count <= dropped_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pix_v1_hit_readout.sv
// Directed bench for pix_v1_hit_readout: window-level result model plus per-cycle FIFO compare.
module tb_pix_v1_hit_readout;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flag = 1'b0, hit = 1'b0, ready = 1'b0;
    logic [24:0] dout;
    logic        dvalid, busy;
    logic [2:0]  fcount;
    logic        flag4 = 1'b0, hit4 = 1'b0, ready4 = 1'b1;
    logic [12:0] dout4;
    logic        dvalid4, busy4;
    logic [2:0]  fcount4;
`ifdef HIT_READOUT_DROP_COUNT_EN
    logic [7:0]  dropped, dropped4;
`endif

    pix_v1_hit_readout #(.TIME_WIDTH(10), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), ._reset(rst_n), .measure_flag(flag), .HIT(hit),
        .data_out(dout), .data_valid(dvalid), .data_ready(ready),
        .fifo_count(fcount), .busy(busy)
`ifdef HIT_READOUT_DROP_COUNT_EN
        , .dropped_count(dropped)
`endif
    );

    pix_v1_hit_readout #(.TIME_WIDTH(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), ._reset(rst_n), .measure_flag(flag4), .HIT(hit4),
        .data_out(dout4), .data_valid(dvalid4), .data_ready(ready4),
        .fifo_count(fcount4), .busy(busy4)
`ifdef HIT_READOUT_DROP_COUNT_EN
        , .dropped_count(dropped4)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_fail = 0;
    logic [24:0] mq[$];
    int          m_drops = 0;
    int          cyc = 0;
    int          push_cyc = -1;
    logic [24:0] push_word = '0;
    logic        busy_exp = 1'b0;
    logic        hrec [0:255];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Synchronized HIT level seen by the block during window cycle k.
    function automatic logic hs(int k);
        if (k - 2 < 0) return 1'b0;
        return hrec[k - 2];
    endfunction

    function automatic logic [63:0] model_word(int n, int tw);
        int maxc, hits, lead, trail, c;
        bit seen;
        maxc = (1 << tw) - 1;
        hits = 0; lead = 0; trail = 0; seen = 0;
        for (int k = 0; k < n; k++) begin
            c = (k > maxc) ? maxc : k;
            if (hs(k) && !hs(k - 1)) begin
                if (!seen) lead = c;
                seen = 1;
                if (hits < 15) hits++;
            end else if (!hs(k) && hs(k - 1) && seen) begin
                trail = c;
            end
        end
        if (!seen) return 64'(1) << (2 * tw);
        if (hs(n - 1)) trail = maxc;
        return (64'(hits) << (2 * tw + 1)) | (64'(lead) << tw) | 64'(trail);
    endfunction

    function automatic logic [24:0] lit_word(int hits, int nohit, int lead, int trail);
        return {4'(hits), 1'(nohit), 10'(lead), 10'(trail)};
    endfunction

    // Expected FIFO contents, advanced on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_drops = 0;
        end else begin
            if (mq.size() > 0 && ready) void'(mq.pop_front());
            if (cyc == push_cyc) begin
                if (mq.size() < 4) mq.push_back(push_word);
                else if (m_drops < 255) m_drops++;
            end
            cyc++;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("data_valid", dvalid, mq.size() > 0);
        chk("fifo_count", fcount, mq.size());
        chk("busy", busy, busy_exp);
        chk("data_out", dout, (mq.size() > 0) ? mq[0] : 25'd0);
`ifdef HIT_READOUT_DROP_COUNT_EN
        chk("dropped_count", dropped, m_drops);
`endif
    end

    task automatic clear_hrec();
        for (int i = 0; i < 256; i++) hrec[i] = 1'b0;
    endtask

    task automatic set_pulses(int start, int width, int period, int count);
        for (int p = 0; p < count; p++)
            for (int i = 0; i < width; i++) hrec[start + p * period + i] = 1'b1;
    endtask

    task automatic run_window(input int n, input logic pop_in_store, output logic [24:0] w);
        repeat (3) @(posedge clk);
        #1 flag = 1'b1; hit = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            hit = hrec[i];
            busy_exp = 1'b1;
            if (i == n - 1) flag = 1'b0;
        end
        @(posedge clk); #1;
        hit = 1'b0;
        w = 25'(model_word(n, 10));
        push_word = w;
        push_cyc = cyc;
        if (pop_in_store) ready = 1'b1;
        @(posedge clk); #1;
        busy_exp = 1'b0;
        if (pop_in_store) ready = 1'b0;
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [24:0] w;
        logic [12:0] w4;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", dvalid, 0);
        chk("rst_data", dout, 0);
        chk("rst_count", fcount, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; ready = 1'b1;

        // Single pulse over window cycles 10..19
        clear_hrec(); set_pulses(10, 10, 0, 1);
        run_window(50, 1'b0, w);
        chk("t1_model", w, lit_word(1, 0, 12, 22));
        chk("t1_word", dout, lit_word(1, 0, 12, 22));

        // No hit; result valid two cycles after the flag falls
        clear_hrec();
        run_window(30, 1'b0, w);
        chk("t2_model", w, lit_word(0, 1, 0, 0));
        chk("t2_valid_latency", dvalid, 1);
        chk("t2_word", dout, lit_word(0, 1, 0, 0));

        // 20 pulses saturate the hit count
        clear_hrec(); set_pulses(2, 2, 4, 20);
        run_window(100, 1'b0, w);
        chk("t3_model", w, lit_word(15, 0, 4, 82));
        chk("t3_word", dout, lit_word(15, 0, 4, 82));

        // Narrow counter saturates; HIT still high at window end
        clear_hrec(); for (int i = 23; i < 40; i++) hrec[i] = 1'b1;
        repeat (3) @(posedge clk);
        #1 flag4 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i == 23) hit4 = 1'b1;
            if (i == 39) flag4 = 1'b0;
        end
        @(posedge clk); #1;
        chk("t4_busy_store", busy4, 1);
        chk("t4_valid_store", dvalid4, 0);
        @(posedge clk); #1;
        w4 = 13'(model_word(40, 4));
        chk("t4_model", w4, {4'd1, 1'b0, 4'hf, 4'hf});
        chk("t4_valid", dvalid4, 1);
        chk("t4_word", dout4, {4'd1, 1'b0, 4'hf, 4'hf});
        chk("t4_count", fcount4, 1);
        chk("t4_busy_idle", busy4, 0);
        hit4 = 1'b0;
        @(posedge clk); #1;
        chk("t4_popped", dvalid4, 0);

        // Six windows with no reader: four held, two dropped
        ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            clear_hrec(); hrec[j] = 1'b1;
            run_window(12, 1'b0, w);
            chk("t5_model", w, lit_word(1, 0, j + 2, j + 3));
        end
        chk("t5_full_count", fcount, 4);
`ifdef HIT_READOUT_DROP_COUNT_EN
        chk("t5_dropped", dropped, 2);
`endif
        ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("t5_drain_order", dout, lit_word(1, 0, j + 2, j + 3));
            @(posedge clk); #1;
        end
        chk("t5_empty", dvalid, 0);

        // Full FIFO, pop coincides with STORE: no drop
        ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            clear_hrec(); hrec[j] = 1'b1;
            run_window(12, 1'b0, w);
        end
        clear_hrec(); hrec[7] = 1'b1;
        run_window(12, 1'b1, w);
        chk("t6_model", w, lit_word(1, 0, 9, 10));
        chk("t6_count", fcount, 4);
        chk("t6_head", dout, lit_word(1, 0, 3, 4));
`ifdef HIT_READOUT_DROP_COUNT_EN
        chk("t6_dropped", dropped, 2);
`endif
        ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Reset in the middle of a window with a word queued
        ready = 1'b0;
        clear_hrec(); hrec[3] = 1'b1;
        run_window(12, 1'b0, w);
        @(posedge clk); #1 flag = 1'b1; hit = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 busy_exp = 1'b1;
        end
        rst_n = 1'b0; flag = 1'b0; hit = 1'b0; busy_exp = 1'b0;
        #1;
        chk("t7_valid", dvalid, 0);
        chk("t7_data", dout, 0);
        chk("t7_count", fcount, 0);
        chk("t7_busy", busy, 0);
`ifdef HIT_READOUT_DROP_COUNT_EN
        chk("t7_dropped", dropped, 0);
`endif
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1; ready = 1'b1;

        clear_hrec(); set_pulses(10, 10, 0, 1);
        run_window(50, 1'b0, w);
        chk("t8_word", dout, lit_word(1, 0, 12, 22));
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
